// File: rtl/avalon_slave_rsa_regs.sv
// avalon_slave_rsa_regs
// Avalon-MM register slave that fronts an RSA core. It provides CTRL, STATUS
// and LEN registers, a 64-byte operand buffer that the core reads, and a
// 64-byte result buffer that the core writes.
// Only address bits [7:0] are decoded, so the map aliases across the rest of
// the 32-bit address space.
// Optional feature: define RSA_SLV_EXTRA_WAIT_EN to insert a WAIT state. This
// gives 2 wait states (3 cycles per transfer) instead of 1 wait state
// (2 cycles per transfer).
module avalon_slave_rsa_regs (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [7:0]  avs_s0_writedata,
  output logic [7:0]  avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  output logic        core_start,
  input  logic        core_done,
  input  logic [5:0]  core_op_addr,
  output logic [7:0]  core_op_data,
  input  logic        core_res_we,
  input  logic [5:0]  core_res_addr,
  input  logic [7:0]  core_res_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_LEN    = 8'h02;
  localparam logic [7:0] OP_FIRST    = 8'h10;
  localparam logic [7:0] OP_LAST     = 8'h4F;

  bus_state_t state_r;
  bus_state_t state_next_s;

  logic [7:0] op_mem_r  [0:63];
  logic [7:0] res_mem_r [0:63];
  logic [7:0] len_r;
  logic [7:0] rdata_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;
  logic       start_r;

  logic [7:0] addr_s;
  logic       req_s;
  logic       rd_only_s;
  logic       in_op_s;
  logic       in_res_s;
  logic [5:0] op_idx_s;
  logic       ack_enter_s;
  logic       wr_commit_s;
  logic       rd_commit_s;
  logic [7:0] rd_mux_s;
  logic       unused_addr_s;

  // Upper address bits alias onto the same 256-byte map.
  assign unused_addr_s = ^avs_s0_address[31:8];

  assign addr_s    = avs_s0_address[7:0];
  assign req_s     = avs_s0_read | avs_s0_write;
  // A read and a write asserted together are treated as a write.
  assign rd_only_s = avs_s0_read & ~avs_s0_write;
  assign in_op_s   = (addr_s >= OP_FIRST) && (addr_s <= OP_LAST);
  assign in_res_s  = (addr_s[7:6] == 2'b10);
  // The 6-bit wrap-around subtraction maps 0x10..0x4F onto 0..63.
  assign op_idx_s  = addr_s[5:0] - 6'h10;

  assign ack_enter_s = (state_next_s == ST_ACK) && (state_r != ST_ACK);
  // Writes and read side effects take place at the edge that ends ACK.
  assign wr_commit_s = (state_r == ST_ACK) && avs_s0_write;
  assign rd_commit_s = (state_r == ST_ACK) && rd_only_s;

  // waitrequest is held high during reset and stays high until ACK.
  assign avs_s0_waitrequest = ~reset_n | (req_s & (state_r != ST_ACK));
  assign avs_s0_readdata    = rdata_r;
  assign core_start         = start_r;
  assign core_op_data       = op_mem_r[core_op_addr];

  // Bus FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus FSM next-state logic. ACK always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
`ifdef RSA_SLV_EXTRA_WAIT_EN
          state_next_s = ST_WAIT;
`else
          state_next_s = ST_ACK;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: state_next_s = ST_ACK;
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Read multiplexer. Unmapped and write-only locations return zero.
  always_comb begin
    rd_mux_s = 8'h00;
    if (addr_s == ADDR_STATUS) begin
      rd_mux_s = {5'b00000, err_r, done_r, busy_r};
    end else if (addr_s == ADDR_LEN) begin
      rd_mux_s = len_r;
    end else if (in_op_s) begin
      rd_mux_s = op_mem_r[op_idx_s];
    end else if (in_res_s) begin
      rd_mux_s = res_mem_r[addr_s[5:0]];
    end else begin
      rd_mux_s = 8'h00;
    end
  end

  // Control, status and readdata registers, including the core handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= 8'h00;
      len_r   <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      start_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      if (ack_enter_s && rd_only_s) begin
        rdata_r <= rd_mux_s;
      end
      if (wr_commit_s) begin
        if ((addr_s == ADDR_CTRL) && avs_s0_writedata[0]) begin
          if (busy_r) begin
            err_r <= 1'b1;
          end else begin
            busy_r  <= 1'b1;
            start_r <= 1'b1;
          end
        end else if (addr_s == ADDR_LEN) begin
          if (busy_r) begin
            err_r <= 1'b1;
          end else begin
            len_r <= avs_s0_writedata;
          end
        end else if (in_op_s && busy_r) begin
          err_r <= 1'b1;
        end
      end
      // A STATUS read clears the sticky flags. The readdata register has
      // already captured the value from before the clear.
      if (rd_commit_s && (addr_s == ADDR_STATUS)) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end
      // core_done overrides a STATUS clear in the same cycle, so the
      // completion is not lost.
      if (core_done && busy_r) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  // Operand buffer. Bus writes are accepted only while the core is idle.
  always_ff @(posedge clk) begin
    if (wr_commit_s && in_op_s && !busy_r) begin
      op_mem_r[op_idx_s] <= avs_s0_writedata;
    end
  end

  // Result buffer. Only the core writes it, independent of bus activity.
  always_ff @(posedge clk) begin
    if (core_res_we) begin
      res_mem_r[core_res_addr] <= core_res_data;
    end
  end

endmodule

// File: tb/tb_avalon_slave_rsa_regs.sv
// Self-checking bench for avalon_slave_rsa_regs (directed vectors plus a
// behavioural model of the register map; honours RSA_SLV_EXTRA_WAIT_EN).
module tb_avalon_slave_rsa_regs;

`ifdef RSA_SLV_EXTRA_WAIT_EN
  localparam int NWAIT = 2;
`else
  localparam int NWAIT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = 32'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        waitrequest;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [5:0]  core_op_addr = 6'h00;
  logic [7:0]  core_op_data;
  logic        core_res_we = 1'b0;
  logic [5:0]  core_res_addr = 6'h00;
  logic [7:0]  core_res_data = 8'h00;

  int checks = 0;
  int failures = 0;

  avalon_slave_rsa_regs dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .avs_s0_address     (address),
    .avs_s0_read        (read),
    .avs_s0_write       (write),
    .avs_s0_writedata   (writedata),
    .avs_s0_readdata    (readdata),
    .avs_s0_waitrequest (waitrequest),
    .core_start         (core_start),
    .core_done          (core_done),
    .core_op_addr       (core_op_addr),
    .core_op_data       (core_op_data),
    .core_res_we        (core_res_we),
    .core_res_addr      (core_res_addr),
    .core_res_data      (core_res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_op [64];
  bit         m_op_ok [64] = '{default: 1'b0};
  logic [7:0] m_res [64];
  logic [7:0] m_len;
  logic       m_busy, m_done, m_err, m_start;
  logic [7:0] m_rdata;
  int         hold;       // posedges seen with the current request held
  int         wait_hi = 0;
  int         start_cnt = 0;

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h01) return {5'b00000, m_err, m_done, m_busy};
    if (a == 8'h02) return m_len;
    if (a >= 8'h10 && a <= 8'h4F) return m_op[int'(a) - 16];
    if (a >= 8'h80 && a <= 8'hBF) return m_res[int'(a) - 128];
    return 8'h00;
  endfunction

  // Model: a transfer answers after NWAIT wait cycles, and its effects land at the end.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_len <= 8'h00;
      m_rdata <= 8'h00; m_start <= 1'b0; hold <= 0;
    end else begin
      m_start <= 1'b0;
      hold <= (read || write) ? hold + 1 : 0;
      if (read && !write && hold == NWAIT - 1) m_rdata <= model_read(address[7:0]);
      if (write && hold == NWAIT) begin
        if (address[7:0] == 8'h00) begin
          if (writedata[0]) begin
            if (m_busy) m_err <= 1'b1;
            else begin m_busy <= 1'b1; m_start <= 1'b1; end
          end
        end else if (address[7:0] == 8'h02) begin
          if (m_busy) m_err <= 1'b1; else m_len <= writedata;
        end else if (address[7:0] >= 8'h10 && address[7:0] <= 8'h4F) begin
          if (m_busy) m_err <= 1'b1;
          else begin
            m_op[int'(address[7:0]) - 16] <= writedata;
            m_op_ok[int'(address[7:0]) - 16] <= 1'b1;
          end
        end
      end
      if (read && !write && hold == NWAIT && address[7:0] == 8'h01) begin
        m_done <= 1'b0; m_err <= 1'b0;
      end
      if (core_done && m_busy) begin m_busy <= 1'b0; m_done <= 1'b1; end
      if (core_res_we) m_res[core_res_addr] <= core_res_data;
    end
  end

  // Compare process: checks every output against the model on each falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("wait_in_reset", 32'(waitrequest), 32'd1);
      chk("rdata_in_reset", 32'(readdata), 32'h00);
      chk("start_in_reset", 32'(core_start), 32'd0);
    end else begin
      chk("waitrequest", 32'(waitrequest), 32'((read || write) && hold != NWAIT));
      chk("readdata", 32'(readdata), 32'(m_rdata));
      chk("core_start", 32'(core_start), 32'(m_start));
      if (m_op_ok[core_op_addr]) chk("core_op_data", 32'(core_op_data), 32'(m_op[core_op_addr]));
      if (waitrequest && (read || write)) wait_hi <= wait_hi + 1;
      if (core_start) start_cnt <= start_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic [31:0] a, input logic r, input logic w,
                      input logic [7:0] d, output logic [7:0] q);
    @(posedge clk); #1;
    address = a; read = r; write = w; writedata = d;
    repeat (NWAIT) @(posedge clk);
    #1 q = readdata;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    int w0, s0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Operand write/read and wait-state count.
    w0 = wait_hi; xfer(32'h10, 1'b0, 1'b1, 8'hA5, q);
    #1 chk("wr_wait_cycles", 32'(wait_hi - w0), 32'(NWAIT));
    w0 = wait_hi; xfer(32'h10, 1'b1, 1'b0, 8'h00, q);
    #1 chk("rd_wait_cycles", 32'(wait_hi - w0), 32'(NWAIT));
    chk("rd_0x10", 32'(q), 32'hA5);
    chk("op_data_idx0", 32'(core_op_data), 32'hA5);

    // LEN register, simultaneous read+write, more operands.
    xfer(32'h02, 1'b0, 1'b1, 8'h40, q);
    xfer(32'h02, 1'b1, 1'b0, 8'h00, q); chk("rd_len", 32'(q), 32'h40);
    xfer(32'h13, 1'b1, 1'b1, 8'h21, q); chk("rdwr_keeps_rdata", 32'(q), 32'h40);
    xfer(32'h13, 1'b1, 1'b0, 8'h00, q); chk("rd_0x13", 32'(q), 32'h21);
    xfer(32'h11, 1'b0, 1'b1, 8'h77, q);
    xfer(32'h12, 1'b0, 1'b1, 8'h44, q);
    core_op_addr = 6'h01; #1 chk("op_data_idx1", 32'(core_op_data), 32'h77);
    core_op_addr = 6'h03; #1 chk("op_data_idx3", 32'(core_op_data), 32'h21);

    // Address aliasing, unmapped and write-only reads.
    xfer(32'h10, 1'b0, 1'b1, 8'h5A, q);
    xfer(32'hFFFF_FF10, 1'b1, 1'b0, 8'h00, q); chk("rd_alias", 32'(q), 32'h5A);
    xfer(32'h60, 1'b1, 1'b0, 8'h00, q); chk("rd_unmapped", 32'(q), 32'h00);
    xfer(32'h00, 1'b1, 1'b0, 8'h00, q); chk("rd_ctrl", 32'(q), 32'h00);

    // Start, busy start, and a dropped operand write.
    s0 = start_cnt; xfer(32'h00, 1'b0, 1'b1, 8'h01, q);
    repeat (3) @(posedge clk); #1 chk("start_pulses", 32'(start_cnt - s0), 32'd1);
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("status_busy", 32'(q), 32'h01);
    s0 = start_cnt; xfer(32'h00, 1'b0, 1'b1, 8'h01, q);
    xfer(32'h12, 1'b0, 1'b1, 8'h99, q);
    repeat (3) @(posedge clk); #1 chk("no_start_busy", 32'(start_cnt - s0), 32'd0);
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("status_err", 32'(q), 32'h05);
    xfer(32'h12, 1'b1, 1'b0, 8'h00, q); chk("op_write_dropped", 32'(q), 32'h44);

    // Completion and clear-on-read.
    pulse_done();
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("status_done", 32'(q), 32'h02);
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("status_cleared", 32'(q), 32'h00);
    pulse_done();
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("done_when_idle", 32'(q), 32'h00);

    // core_done coinciding with the STATUS clear.
    xfer(32'h00, 1'b0, 1'b1, 8'h01, q);
    fork
      xfer(32'h01, 1'b1, 1'b0, 8'h00, q);
      begin
        @(posedge clk); #1;
        repeat (NWAIT) @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
      end
    join
    chk("status_pre_done", 32'(q), 32'h01);
    xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("done_survives_clear", 32'(q), 32'h02);

    // Result buffer.
    @(posedge clk); #1 core_res_we = 1'b1; core_res_addr = 6'h03; core_res_data = 8'h3C;
    @(posedge clk); #1 core_res_we = 1'b0;
    xfer(32'h83, 1'b1, 1'b0, 8'h00, q); chk("rd_res", 32'(q), 32'h3C);
    xfer(32'h83, 1'b0, 1'b1, 8'hFF, q);
    xfer(32'h83, 1'b1, 1'b0, 8'h00, q); chk("res_ro", 32'(q), 32'h3C);
    fork
      xfer(32'h83, 1'b1, 1'b0, 8'h00, q);
      begin
        @(posedge clk); #1;
        repeat (NWAIT - 1) @(posedge clk);
        #1 core_res_we = 1'b1; core_res_data = 8'h55;
        @(posedge clk); #1 core_res_we = 1'b0;
      end
    join
    chk("res_same_cycle_old", 32'(q), 32'h3C);
    xfer(32'h83, 1'b1, 1'b0, 8'h00, q); chk("res_new", 32'(q), 32'h55);

    // Reset in the middle of a write to 0x11, once in each wait/ack cycle.
    for (int k = 1; k <= NWAIT; k++) begin
      @(posedge clk); #1 address = 32'h11; write = 1'b1; writedata = 8'hEE;
      repeat (k) @(posedge clk);
      #2 reset_n = 1'b0; write = 1'b0;
      #1 chk("wait_reset_direct", 32'(waitrequest), 32'd1);
      @(posedge clk); #1 reset_n = 1'b1;
      xfer(32'h11, 1'b1, 1'b0, 8'h00, q); chk("abort_no_write", 32'(q), 32'h77);
      xfer(32'h01, 1'b1, 1'b0, 8'h00, q); chk("status_after_reset", 32'(q), 32'h00);
    end
    xfer(32'h02, 1'b1, 1'b0, 8'h00, q); chk("len_after_reset", 32'(q), 32'h00);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
